// File: rtl/mips_pkg.sv
// mips_pkg -- shared MDU definitions.
//   mdu_op_e    : op-field encodings (MDU_MULT..MDU_MSUB)
//   mdu_state_e : MDU sequencer states (ST_IDLE / ST_BUSY)
package mips_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MADD  = 3'd6,
    MDU_MSUB  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/e_mdu_calc.sv
// e_mdu_calc -- combinational result generator for the MDU.
//   op       : operation (mips_pkg::mdu_op_e)
//   a, b     : operands
//   hi, lo   : current HI/LO (accumulate base for MADD/MSUB, hold value otherwise)
//   res_hi/lo: result to commit when the operation retires
//   res_wr   : 1 when the result is to be committed (0 for divide by zero
//              and for ops that do not produce a deferred result)
module e_mdu_calc
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             res_wr
);

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               b_zero, b_m1;
  logic [WIDTH-1:0]   b_sdiv, b_udiv;
  logic signed [WIDTH-1:0] quot_s, rem_s;
  logic [WIDTH-1:0]   quot_u, rem_u;

  // The low 2*WIDTH bits of a product of sign-extended operands equal the
  // signed product, so an unsigned multiplier serves both cases.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign b_zero = (b == '0);
  assign b_m1   = &b;

  // Divisors 0 and -1 are steered away from the signed divider: 0 is never
  // committed and -1 is handled as negation, which also yields the wrapped
  // most-negative quotient without an overflowing division.
  assign b_sdiv = (b_zero || b_m1) ? WIDTH'(1) : b;
  assign b_udiv = b_zero ? WIDTH'(1) : b;
  assign quot_s = $signed(a) / $signed(b_sdiv);
  assign rem_s  = $signed(a) % $signed(b_sdiv);
  assign quot_u = a / b_udiv;
  assign rem_u  = a % b_udiv;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    res_wr = 1'b0;
    case (op)
      MDU_MULT: begin
        {res_hi, res_lo} = prod_s;
        res_wr           = 1'b1;
      end
      MDU_MULTU: begin
        {res_hi, res_lo} = prod_u;
        res_wr           = 1'b1;
      end
      MDU_MADD: begin
        {res_hi, res_lo} = {hi, lo} + prod_s;
        res_wr           = 1'b1;
      end
      MDU_MSUB: begin
        {res_hi, res_lo} = {hi, lo} - prod_s;
        res_wr           = 1'b1;
      end
      MDU_DIV: begin
        if (!b_zero) begin
          res_lo = b_m1 ? (WIDTH'(0) - a) : quot_s;
          res_hi = b_m1 ? '0 : rem_s;
          res_wr = 1'b1;
        end
      end
      MDU_DIVU: begin
        if (!b_zero) begin
          res_lo = quot_u;
          res_hi = rem_u;
          res_wr = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// e_mdu -- multi-cycle multiply/divide unit with architectural HI/LO.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   start  : issue op on this edge (ignored while busy)
//   op     : 0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO 6 MADD 7 MSUB
//   a, b   : operands (a only for MTHI/MTLO)
//   busy   : operation in flight
//   hi, lo : HI/LO registers, updated on the edge busy drops
// Build option: define MDU_MADD_EN to enable MADD/MSUB; otherwise ops 6/7
// are no-ops.
module e_mdu
  import mips_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  mdu_op_e          op_e;
  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic             res_wr_q, res_wr_d;
  logic [WIDTH-1:0] calc_hi, calc_lo;
  logic             calc_wr;
  logic             long_op;
  logic [CNT_W-1:0] op_lat;

  assign op_e = mdu_op_e'(op);

  e_mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op     (op_e),
    .a      (a),
    .b      (b),
    .hi     (hi_q),
    .lo     (lo_q),
    .res_hi (calc_hi),
    .res_lo (calc_lo),
    .res_wr (calc_wr)
  );

  // Which ops occupy the unit, and for how long.
  always_comb begin
    long_op = 1'b0;
    op_lat  = '0;
    case (op_e)
      MDU_MULT, MDU_MULTU: begin
        long_op = 1'b1;
        op_lat  = CNT_W'(MUL_LAT);
      end
      MDU_DIV, MDU_DIVU: begin
        long_op = 1'b1;
        op_lat  = CNT_W'(DIV_LAT);
      end
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MSUB: begin
        long_op = 1'b1;
        op_lat  = CNT_W'(MUL_LAT);
      end
`endif
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_wr_q <= res_wr_d;
    end
  end

  // Next-state logic. The result is captured at issue; HI/LO only change
  // on the retiring edge, so MADD/MSUB see a stable accumulate base.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_wr_d = res_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (long_op) begin
            state_d  = ST_BUSY;
            cnt_d    = op_lat;
            res_hi_d = calc_hi;
            res_lo_d = calc_lo;
            res_wr_d = calc_wr;
          end else if (op_e == MDU_MTHI) begin
            hi_d = a;
          end else if (op_e == MDU_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    busy = (state_q == ST_BUSY);
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and HI/LO width (legal: 8..64).
REQ-002 SHALL have parameter MUL_LAT, default 5, meaning the busy cycles per multiply (legal: >=1).
REQ-003 SHALL have parameter DIV_LAT, default 10, meaning the busy cycles per divide (legal: >=1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: issue the op on this edge.
REQ-007 SHALL have port op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: operands (a only for MTHI/MTLO).
REQ-009 SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-010 SHALL have ports hi and lo, output, WIDTH bits each: architectural HI/LO registers.

Function
REQ-011 SHALL be IDLE/BUSY FSM; a start in IDLE with op 0-3 (or 6-7 when enabled) latches the result and enters BUSY with counter = MUL_LAT or DIV_LAT.
REQ-012 SHALL assert busy from the cycle after the accepted start for exactly LAT cycles, then return to IDLE.
REQ-013 SHALL update hi/lo on the same edge busy deasserts, never earlier; hi/lo hold old values while busy.
REQ-014 SHALL ignore start (any op) while busy; no state change, no queueing.
REQ-015 SHALL execute MTHI/MTLO in IDLE in one cycle: hi (resp. lo) <= a on that edge, busy stays 0.
REQ-016 SHALL compute MULT as signed 2*WIDTH product and MULTU as unsigned; {hi,lo} = product.
REQ-017 SHALL compute DIV signed (quotient truncated toward zero, remainder sign follows a) and DIVU unsigned; lo = quotient, hi = remainder.
REQ-018 SHALL, on divide with b == 0, run the full DIV_LAT busy period and leave hi/lo unchanged.
REQ-019 SHALL, for signed DIV with a = most-negative and b = -1, produce lo = a and hi = 0.
REQ-020 SHALL use a counter of width $clog2(max(MUL_LAT,DIV_LAT)+1); no wrap occurs.
REQ-021 SHALL, with LAT = 1, hold busy for one cycle and commit on the following edge.

Reset
REQ-022 SHALL on reset low, immediately and asynchronously, force hi = 0, lo = 0, busy = 0, FSM = IDLE, counter = 0.
REQ-023 SHALL discard an in-flight operation when reset asserts mid-BUSY; hi/lo are not committed.
REQ-024 SHALL accept a start on the first rising edge after reset releases.

Configuration
REQ-025 SHALL honour macro MDU_MADD_EN: when defined, op 6 sets {hi,lo} += signed a*b and op 7 sets {hi,lo} -= signed a*b, both with MUL_LAT busy cycles and mod 2^(2*WIDTH) wrap.
REQ-026 SHALL, without MDU_MADD_EN, treat ops 6/7 as no-ops: busy stays 0 and hi/lo are unchanged.

Structure
REQ-027 SHALL take op encodings (MDU_MULT..MDU_MSUB) and FSM state constants from shared package mips_pkg.
REQ-028 SHALL place the combinational signed/unsigned multiply and divide result generation in one sub-module e_mdu_calc; e_mdu holds the FSM, counter and HI/LO.

Verification
REQ-029 SHALL cover: MULT a=0xFFFFFFFE, b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-030 SHALL cover: DIV a=-7, b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-031 SHALL cover: DIVU b=0 after hi=0x11, lo=0x22 -> busy 10 cycles, hi/lo stay 0x11/0x22.
REQ-032 SHALL cover: MTHI a=0x1234 then a MULTU start while busy -> hi=0x1234 next edge; the second start is ignored and hi/lo equal the first result.
REQ-033 SHALL cover: reset low at busy cycle 3 of DIV -> busy=0, hi=lo=0 immediately, with no commit after release.
REQ-034 SHALL cover, with MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADD a=1, b=1 -> hi=1, lo=0; without the macro -> unchanged and busy=0.
